// File: rtl/ff_video_pkg.sv
// Shared video constants: default 640x480@60 timing, HT/VT
// derivation, pixel bit-field positions, FIFO geometry, FSM states.
package ff_video_pkg;

   localparam int H_ACTIVE_D = 640;
   localparam int H_FP_D     = 16;
   localparam int H_SYNC_D   = 96;
   localparam int H_BP_D     = 48;
   localparam int V_ACTIVE_D = 480;
   localparam int V_FP_D     = 10;
   localparam int V_SYNC_D   = 2;
   localparam int V_BP_D     = 33;

   function automatic int line_total(input int act, input int fp,
                                     input int sy, input int bp);
      return act + fp + sy + bp;
   endfunction

   localparam int HT_D = line_total(H_ACTIVE_D, H_FP_D, H_SYNC_D, H_BP_D);
   localparam int VT_D = line_total(V_ACTIVE_D, V_FP_D, V_SYNC_D, V_BP_D);

   // pixel byte layout {blue, green, red}
   localparam int PIX_W   = 8;
   localparam int BLU_MSB = 7;
   localparam int BLU_LSB = 6;
   localparam int GRN_MSB = 5;
   localparam int GRN_LSB = 3;
   localparam int RED_MSB = 2;
   localparam int RED_LSB = 0;

   // FIFO entry is {sof, pixel}
   localparam int FIFO_W     = PIX_W + 1;
   localparam int FIFO_DEPTH = 4;
   localparam int FIFO_AW    = 2;
   localparam int SOF_BIT    = PIX_W;

   typedef enum logic {
      ST_ALIGN = 1'b0,
      ST_RUN   = 1'b1
   } tx_state_e;

endpackage

// File: rtl/ff_pix_fifo.sv
// 4-deep first-word-fall-through pixel FIFO, count-based full/empty.
// Ports: clk, rst_n, push/din, pop, dout (head), full, empty.
module ff_pix_fifo
   import ff_video_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic [FIFO_W-1:0] din,
   input  logic              pop,
   output logic [FIFO_W-1:0] dout,
   output logic              full,
   output logic              empty
);

   logic [FIFO_W-1:0]  mem_q [FIFO_DEPTH];
   logic [FIFO_W-1:0]  mem_d [FIFO_DEPTH];
   logic [FIFO_AW-1:0] wr_q, wr_d;
   logic [FIFO_AW-1:0] rd_q, rd_d;
   logic [FIFO_AW:0]   cnt_q, cnt_d;
   logic               do_push;
   logic               do_pop;

   assign full  = (cnt_q == (FIFO_AW+1)'(FIFO_DEPTH));
   assign empty = (cnt_q == '0);
   assign dout  = mem_q[rd_q];

   always_comb begin
      mem_d   = mem_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      cnt_d   = cnt_q;
      do_push = push && !full;
      do_pop  = pop && !empty;
      if (do_push) begin
         mem_d[wr_q] = din;
         wr_d        = wr_q + 1'b1;
      end
      if (do_pop) begin
         rd_d = rd_q + 1'b1;
      end
      if (do_push && !do_pop) begin
         cnt_d = cnt_q + 1'b1;
      end else if (do_pop && !do_push) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/vga_pixel_tx.sv
// VGA timing generator fed from a valid/ready pixel stream via a FIFO.
// Ports: clk25m, reset_n, pix_* stream in; syncs/blank/rgb/status out.
module vga_pixel_tx
   import ff_video_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_D,
   parameter int H_FP     = H_FP_D,
   parameter int H_SYNC   = H_SYNC_D,
   parameter int H_BP     = H_BP_D,
   parameter int V_ACTIVE = V_ACTIVE_D,
   parameter int V_FP     = V_FP_D,
   parameter int V_SYNC   = V_SYNC_D,
   parameter int V_BP     = V_BP_D
) (
   input  logic             clk25m,
   input  logic             reset_n,
   input  logic [PIX_W-1:0] pix_data,
   input  logic             pix_sof,
   input  logic             pix_valid,
   output logic             pix_ready,
   output logic             hsync_o,
   output logic             vsync_o,
   output logic             blank_o,
   output logic [PIX_W-1:0] rgb_o,
   output logic             frame_start_o,
   output logic             underflow_o,
   output logic             desync_o
);

   localparam int HT = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int VT = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam int HW = $clog2(HT);
   localparam int VW = $clog2(VT);

   localparam logic [HW-1:0] H_LAST = HW'(HT - 1);
   localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [VW-1:0] V_LAST = VW'(VT - 1);
   localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic [HW-1:0]    hcnt_q, hcnt_d;
   logic [VW-1:0]    vcnt_q, vcnt_d;
   tx_state_e        state_q, state_d;
   logic             rdy_q, rdy_d;
   logic             hs_q, hs_d;
   logic             vs_q, vs_d;
   logic             blank_q, blank_d;
   logic [PIX_W-1:0] rgb_q, rgb_d;
   logic             fs_q, fs_d;
   logic             uf_q, uf_d;
   logic             ds_q, ds_d;

   logic              active;
   logic              at0;
   logic              fifo_push;
   logic              fifo_pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [FIFO_W-1:0] fifo_dout;
   logic              head_sof;

   // rdy_q keeps pix_ready low through reset and the cycle it lifts
   assign pix_ready = rdy_q && !fifo_full;
   assign fifo_push = pix_valid && pix_ready;
   assign head_sof  = fifo_dout[SOF_BIT];

   ff_pix_fifo u_fifo (
      .clk   (clk25m),
      .rst_n (reset_n),
      .push  (fifo_push),
      .din   ({pix_sof, pix_data}),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      hcnt_d   = (hcnt_q == H_LAST) ? '0 : hcnt_q + 1'b1;
      vcnt_d   = vcnt_q;
      if (hcnt_q == H_LAST) begin
         vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
      end
      active   = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
      at0      = (hcnt_q == '0) && (vcnt_q == '0);
      rdy_d    = 1'b1;
      state_d  = state_q;
      fifo_pop = 1'b0;
      rgb_d    = '0;
      ds_d     = 1'b0;
      unique case (state_q)
         ST_ALIGN: begin
            // flush stale pixels; hold a frame head until (0,0)
            if (!fifo_empty) begin
               if (!head_sof) begin
                  fifo_pop = 1'b1;
               end else if (at0) begin
                  fifo_pop = 1'b1;
                  state_d  = ST_RUN;
                  rgb_d    = fifo_dout[PIX_W-1:0];
               end
            end
         end
         ST_RUN: begin
            if (active && !fifo_empty) begin
               // sof must coincide exactly with (0,0)
               if (head_sof != at0) begin
                  ds_d    = 1'b1;
                  state_d = ST_ALIGN;
               end else begin
                  fifo_pop = 1'b1;
                  rgb_d    = fifo_dout[PIX_W-1:0];
               end
            end
         end
         default: state_d = ST_ALIGN;
      endcase
      hs_d    = !((hcnt_q >= H_SS) && (hcnt_q <= H_SE));
      vs_d    = !((vcnt_q >= V_SS) && (vcnt_q <= V_SE));
      blank_d = !active;
      fs_d    = at0;
      // frame start restarts the sticky flag with this cycle's status
      uf_d    = (at0 ? 1'b0 : uf_q) | (active && fifo_empty);
   end

   always_ff @(posedge clk25m or negedge reset_n) begin
      if (!reset_n) begin
         hcnt_q  <= '0;
         vcnt_q  <= '0;
         state_q <= ST_ALIGN;
         rdy_q   <= 1'b0;
         hs_q    <= 1'b1;
         vs_q    <= 1'b1;
         blank_q <= 1'b1;
         rgb_q   <= '0;
         fs_q    <= 1'b0;
         uf_q    <= 1'b0;
         ds_q    <= 1'b0;
      end else begin
         hcnt_q  <= hcnt_d;
         vcnt_q  <= vcnt_d;
         state_q <= state_d;
         rdy_q   <= rdy_d;
         hs_q    <= hs_d;
         vs_q    <= vs_d;
         blank_q <= blank_d;
         rgb_q   <= rgb_d;
         fs_q    <= fs_d;
         uf_q    <= uf_d;
         ds_q    <= ds_d;
      end
   end

   assign hsync_o       = hs_q;
   assign vsync_o       = vs_q;
   assign blank_o       = blank_q;
   assign rgb_o         = rgb_q;
   assign frame_start_o = fs_q;
   assign underflow_o   = uf_q;
   assign desync_o      = ds_q;

endmodule

// File: tb/tb_vga_pixel_tx.sv
// Directed bench for vga_pixel_tx on a reduced 15x8 raster.
// Output index k counts clocks from the first frame_start after reset.
module tb_vga_pixel_tx;

   // HT = 15 (hsync 10..12), VT = 8 (vsync lines 5..6), 32 px/frame
   localparam int HA = 8;
   localparam int HF = 2;
   localparam int HS = 3;
   localparam int HB = 2;
   localparam int VA = 4;
   localparam int VF = 1;
   localparam int VS = 2;
   localparam int VB = 1;

   logic       clk25m = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] pix_data = '0;
   logic       pix_sof = 1'b0;
   logic       pix_valid = 1'b0;
   logic       pix_ready;
   logic       hsync_o;
   logic       vsync_o;
   logic       blank_o;
   logic [7:0] rgb_o;
   logic       frame_start_o;
   logic       underflow_o;
   logic       desync_o;

   int n_vec = 0;
   int n_bad = 0;
   int kpos = 0;
   int src_acc = 0;
   int ds_cnt = 0;
   bit fire_pend = 1'b0;
   logic [8:0] src_q[$];

   always #5 clk25m = ~clk25m;

   vga_pixel_tx #(
      .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
      .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
   ) dut (
      .clk25m        (clk25m),
      .reset_n       (reset_n),
      .pix_data      (pix_data),
      .pix_sof       (pix_sof),
      .pix_valid     (pix_valid),
      .pix_ready     (pix_ready),
      .hsync_o       (hsync_o),
      .vsync_o       (vsync_o),
      .blank_o       (blank_o),
      .rgb_o         (rgb_o),
      .frame_start_o (frame_start_o),
      .underflow_o   (underflow_o),
      .desync_o      (desync_o)
   );

   // source: presents queue head, retires it after an accepted edge
   always @(negedge clk25m) begin
      if (fire_pend && reset_n && src_q.size() > 0) begin
         void'(src_q.pop_front());
         src_acc++;
      end
      if (src_q.size() > 0) begin
         pix_valid = 1'b1;
         pix_sof   = src_q[0][8];
         pix_data  = src_q[0][7:0];
      end else begin
         pix_valid = 1'b0;
         pix_sof   = 1'b0;
         pix_data  = '0;
      end
      fire_pend = pix_valid && pix_ready;
   end

   always @(negedge clk25m) begin
      if (desync_o) ds_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (k=%0d)", tag, obs, exp, kpos);
      end
   endtask

   task automatic goto(input int k);
      while (kpos < k) begin
         @(negedge clk25m);
         kpos++;
      end
   endtask

   task automatic push_frame(input logic [7:0] base, input int sof2);
      for (int i = 0; i < 32; i++) begin
         src_q.push_back({(i == 0 || i == sof2), 8'(base + 8'(i))});
      end
   endtask

   task automatic release_rst();
      @(negedge clk25m);
      reset_n = 1'b1;
      @(negedge clk25m);
      kpos = 0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_hs"}, hsync_o, 1);
      chk({tag, "_vs"}, vsync_o, 1);
      chk({tag, "_blank"}, blank_o, 1);
      chk({tag, "_rgb"}, rgb_o, 0);
      chk({tag, "_fs"}, frame_start_o, 0);
      chk({tag, "_uf"}, underflow_o, 0);
      chk({tag, "_ds"}, desync_o, 0);
      chk({tag, "_rdy"}, pix_ready, 0);
   endtask

   initial begin
      // reset state
      repeat (3) @(negedge clk25m);
      chk_reset_vals("rst");

      // counter stream: frame A (0..31), then only 4 px of frame B
      push_frame(8'h00, -1);
      for (int i = 0; i < 4; i++) begin
         src_q.push_back({(i == 0), 8'(8'h20 + 8'(i))});
      end
      release_rst();
      chk("fs_first", frame_start_o, 1);
      chk("uf_first", underflow_o, 1);
      chk("rgb_first", rgb_o, 0);
      goto(120);
      chk("fsA", frame_start_o, 1);
      chk("rgbA0", rgb_o, 8'h00);
      chk("ufA0", underflow_o, 0);
      goto(121); chk("rgbA1", rgb_o, 8'h01);
      goto(127); chk("rgbA7", rgb_o, 8'h07);
      goto(128); chk("blankA8", blank_o, 1);
      chk("rgbA8", rgb_o, 0);
      goto(129); chk("hs9", hsync_o, 1);
      goto(130); chk("hs10", hsync_o, 0);
      goto(132); chk("hs12", hsync_o, 0);
      goto(133); chk("hs13", hsync_o, 1);
      goto(135); chk("rgbA8l1", rgb_o, 8'h08);
      chk("blankl1", blank_o, 0);
      goto(194); chk("vs4", vsync_o, 1);
      goto(195); chk("vs5", vsync_o, 0);
      goto(224); chk("vs6", vsync_o, 0);
      goto(225); chk("vs7", vsync_o, 1);

      // frame B starves after 4 pixels
      goto(240); chk("fsB", frame_start_o, 1);
      chk("rgbB0", rgb_o, 8'h20);
      goto(243); chk("rgbB3", rgb_o, 8'h23);
      chk("ufB3", underflow_o, 0);
      goto(244); chk("rgbB4", rgb_o, 0);
      chk("ufB4", underflow_o, 1);
      goto(270); chk("ufB30", underflow_o, 1);
      chk("rgbB30", rgb_o, 0);
      goto(305);
      push_frame(8'h40, 11);
      goto(359); chk("ufB_end", underflow_o, 1);
      goto(360); chk("fsC", frame_start_o, 1);
      chk("ufC_clr", underflow_o, 0);
      chk("rgbC0", rgb_o, 8'h40);

      // stray sof at line 1 pixel 3
      ds_cnt = 0;
      goto(377); chk("rgbC10", rgb_o, 8'h4a);
      goto(378); chk("ds_hit", desync_o, 1);
      chk("rgb_ds", rgb_o, 0);
      goto(379); chk("ds_gone", desync_o, 0);
      goto(390); chk("rgb_align", rgb_o, 0);
      goto(479); chk("ds_cnt", ds_cnt, 1);
      goto(480); chk("fs_realign", frame_start_o, 1);
      chk("rgb_realign", rgb_o, 8'h4b);
      goto(481); chk("rgb_realign1", rgb_o, 8'h4c);

      // 5 stray pixels ahead of the first sof
      reset_n = 1'b0;
      src_q.delete();
      repeat (3) @(negedge clk25m);
      src_acc = 0;
      for (int i = 0; i < 5; i++) begin
         src_q.push_back({1'b0, 8'(8'ha0 + 8'(i))});
      end
      push_frame(8'h50, -1);
      push_frame(8'h70, -1);
      release_rst();
      chk("fsS_first", frame_start_o, 1);
      chk("rgbS_first", rgb_o, 0);
      goto(20); chk("rgb_align2", rgb_o, 0);
      goto(100); chk("rdy_full", pix_ready, 0);
      chk("acc9", src_acc, 9);
      for (int v = 0; v < VA; v++) begin
         for (int h = 0; h < HA; h++) begin
            goto(120 + v * 15 + h);
            chk("seqS", rgb_o, 8'h50 + 8'(v * HA + h));
         end
      end
      goto(230); chk("rdy_vblank", pix_ready, 0);
      goto(240); chk("fsT", frame_start_o, 1);
      chk("rgbT0", rgb_o, 8'h70);

      // asynchronous reset mid-frame
      goto(275); chk("rgbT21", rgb_o, 8'h85);
      #2 reset_n = 1'b0;
      #1 chk_reset_vals("async");
      src_q.delete();
      repeat (2) @(negedge clk25m);
      release_rst();
      chk("fs_restart", frame_start_o, 1);
      chk("blank_restart", blank_o, 0);
      chk("rgb_restart", rgb_o, 0);
      chk("rdy_restart", pix_ready, 1);
      goto(9); chk("hs_r9", hsync_o, 1);
      goto(10); chk("hs_r10", hsync_o, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
